// File: rtl/ifq_param.sv
// Instruction fetch queue: buffers whole I-cache lines and hands decode one word per pop.
// Define IFQ_BYPASS_EN to forward an arriving line straight to the head when the queue is empty.
module ifq_param #(
    parameter int          WORDS    = 4,
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic                           i_clk,
    input  logic                           i_rst_n,
    input  logic [32*WORDS-1:0]            i_line,
    input  logic                           i_line_valid,
    output logic                           o_req_en,
    output logic [31:0]                    o_req_pc,
    input  logic                           i_pop,
    input  logic                           i_pop2,
    input  logic                           i_redirect,
    input  logic [31:0]                    i_redirect_pc,
    output logic                           o_valid,
    output logic [31:0]                    o_instr,
    output logic [31:0]                    o_pc,
    output logic [$clog2(WORDS*DEPTH):0]   o_count,
    output logic                           o_full,
    output logic                           o_empty
);
    localparam int WB = $clog2(WORDS);
    localparam int DB = $clog2(DEPTH);
    localparam int L  = WB + 2;
    localparam int LW = DB + 1;
    localparam int RW = DB + WB + 1;
    localparam logic [31:0] LINE_BYTES = 32'(4 * WORDS);

    logic [LW-1:0] wp_reg;
    logic [RW-1:0] rp_reg;
    logic [31:0]   pc_reg;
    logic [31:0]   req_reg;

    logic [31:0]   mem [DEPTH*WORDS];
    logic [31:0]   line_words [WORDS];

    logic [LW-1:0] rp_line;
    logic [RW-1:0] diff;
    logic [RW-1:0] count;
    logic          same_line;
    logic          full;
    logic          empty;
    logic          bypass;
    logic          valid;
    logic          wr_en;
    logic          do_pop1;
    logic          do_pop2;
    logic [31:0]   target_line;
    logic [31:0]   head_word;
    logic          unused_pc_bits;

    generate
        for (genvar gi = 0; gi < WORDS; gi++) begin : g_split
            assign line_words[gi] = i_line[32*gi +: 32];
        end
    endgenerate

    assign rp_line     = rp_reg[RW-1:WB];
    assign target_line = {i_redirect_pc[31:L], {L{1'b0}}};
    assign diff        = {wp_reg, {WB{1'b0}}} - rp_reg;
    // After a mid-line redirect rp sits inside a line not yet written; nothing is stored then.
    assign same_line   = (rp_line == wp_reg);
    assign count       = same_line ? '0 : diff;
    assign empty       = (count == '0);
    assign full        = (rp_line[DB-1:0] == wp_reg[DB-1:0]) && (rp_line[DB] != wp_reg[DB]);

`ifdef IFQ_BYPASS_EN
    assign bypass = empty & i_line_valid & ~i_redirect;
`else
    assign bypass = 1'b0;
`endif

    assign valid     = ~empty | bypass;
    assign head_word = bypass ? line_words[rp_reg[WB-1:0]] : mem[rp_reg[RW-2:0]];
    assign wr_en     = i_line_valid & ~full & ~i_redirect;
    assign do_pop2   = i_pop2 & (count >= RW'(2));
    assign do_pop1   = ~i_pop2 & i_pop & valid;

    assign o_req_en  = ~full;
    assign o_req_pc  = i_redirect ? target_line : req_reg;
    assign o_valid   = valid;
    assign o_instr   = valid ? head_word : 32'h0;
    assign o_pc      = pc_reg;
    assign o_count   = count;
    assign o_full    = full;
    assign o_empty   = empty;

    assign unused_pc_bits = &{1'b0, i_redirect_pc[1:0]};

    // Line storage has no reset; contents behind rp are never exposed.
    always_ff @(posedge i_clk) begin
        if (wr_en) begin
            for (int k = 0; k < WORDS; k++) begin
                mem[{wp_reg[DB-1:0], k[WB-1:0]}] <= line_words[k];
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wp_reg  <= '0;
            rp_reg  <= '0;
            pc_reg  <= RESET_PC;
            req_reg <= RESET_PC;
        end else if (i_redirect) begin
            wp_reg  <= '0;
            rp_reg  <= {{(RW-WB){1'b0}}, i_redirect_pc[L-1:2]};
            pc_reg  <= i_redirect_pc;
            req_reg <= target_line + LINE_BYTES;
        end else begin
            if (wr_en) begin
                wp_reg  <= wp_reg + LW'(1);
                req_reg <= req_reg + LINE_BYTES;
            end
            if (do_pop2) begin
                rp_reg <= rp_reg + RW'(2);
                pc_reg <= pc_reg + 32'd8;
            end else if (do_pop1) begin
                rp_reg <= rp_reg + RW'(1);
                pc_reg <= pc_reg + 32'd4;
            end
        end
    end
endmodule

// File: tb/tb_ifq_param.sv
// Scoreboard bench for ifq_param: a word-queue reference model predicts every cycle's outputs.
module tb_ifq_param;
    localparam int          WORDS    = 4;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0;
    localparam int          CW       = $clog2(WORDS*DEPTH) + 1;
    localparam int          L        = $clog2(WORDS) + 2;

    logic                 clk;
    logic                 i_rst_n;
    logic [32*WORDS-1:0]  i_line;
    logic                 i_line_valid;
    logic                 o_req_en;
    logic [31:0]          o_req_pc;
    logic                 i_pop;
    logic                 i_pop2;
    logic                 i_redirect;
    logic [31:0]          i_redirect_pc;
    logic                 o_valid;
    logic [31:0]          o_instr;
    logic [31:0]          o_pc;
    logic [CW-1:0]        o_count;
    logic                 o_full;
    logic                 o_empty;

    ifq_param #(.WORDS(WORDS), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .i_clk(clk), .i_rst_n(i_rst_n), .i_line(i_line), .i_line_valid(i_line_valid),
        .o_req_en(o_req_en), .o_req_pc(o_req_pc), .i_pop(i_pop), .i_pop2(i_pop2),
        .i_redirect(i_redirect), .i_redirect_pc(i_redirect_pc), .o_valid(o_valid),
        .o_instr(o_instr), .o_pc(o_pc), .o_count(o_count), .o_full(o_full), .o_empty(o_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        bit          last;
    } word_t;

    typedef struct {
        bit          chk_data;
        bit          valid;
        logic [31:0] instr;
        logic [31:0] pc;
        int          count;
        bit          full;
        bit          empty;
        logic [31:0] req_pc;
    } exp_t;

    word_t       wq[$];
    exp_t        sb[$];
    int          skip;
    logic [31:0] next_line_pc;
    logic [31:0] req_m;
    int          errors = 0;
    int          checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int lines_held();
        int n = 0;
        foreach (wq[i]) if (wq[i].last) n++;
        return n;
    endfunction

    task automatic model_reset();
        wq.delete();
        skip         = 0;
        next_line_pc = RESET_PC;
        req_m        = RESET_PC;
    endtask

    function automatic logic [32*WORDS-1:0] mk_line(input logic [31:0] base);
        logic [32*WORDS-1:0] v;
        for (int k = 0; k < WORDS; k++) v[32*k +: 32] = base + 32'(k);
        return v;
    endfunction

    function automatic logic [32*WORDS-1:0] rnd_line();
        logic [32*WORDS-1:0] v;
        for (int k = 0; k < WORDS; k++) v[32*k +: 32] = $urandom;
        return v;
    endfunction

    // One stimulus cycle: drive at negedge, queue the expected outputs, then advance the model.
    task automatic cycle(input bit rst, input bit lv, input logic [32*WORDS-1:0] line,
                         input bit pop, input bit pop2, input bit redir, input logic [31:0] rpc);
        exp_t  e;
        int    cnt;
        int    npop;
        bit    bp;
        bit    full;
        bit    valid;
        word_t w;
        @(negedge clk);
        i_rst_n       = !rst;
        i_line_valid  = rst ? 1'b0 : lv;
        i_line        = line;
        i_pop         = rst ? 1'b0 : pop;
        i_pop2        = rst ? 1'b0 : pop2;
        i_redirect    = rst ? 1'b0 : redir;
        i_redirect_pc = rpc;
        if (rst) begin
            model_reset();
            e = '{chk_data: 1'b1, valid: 1'b0, instr: 32'h0, pc: RESET_PC, count: 0,
                  full: 1'b0, empty: 1'b1, req_pc: RESET_PC};
            sb.push_back(e);
        end else begin
            cnt  = wq.size();
            full = (lines_held() == DEPTH);
            bp   = 1'b0;
`ifdef IFQ_BYPASS_EN
            bp   = (cnt == 0) && lv && !redir;
`endif
            valid      = (cnt > 0) || bp;
            e.valid    = valid;
            e.chk_data = valid;
            e.count    = cnt;
            e.full     = full;
            e.empty    = (cnt == 0);
            e.req_pc   = redir ? {rpc[31:L], {L{1'b0}}} : req_m;
            e.instr    = 32'h0;
            e.pc       = 32'h0;
            if (cnt > 0) begin
                e.instr = wq[0].instr;
                e.pc    = wq[0].pc;
            end else if (bp) begin
                e.instr = line[32*skip +: 32];
                e.pc    = next_line_pc + 32'(4*skip);
            end
            sb.push_back(e);
            if (redir) begin
                wq.delete();
                skip         = int'(rpc[L-1:2]);
                next_line_pc = {rpc[31:L], {L{1'b0}}};
                req_m        = next_line_pc + 32'(4*WORDS);
            end else begin
                if (lv && !full) begin
                    for (int k = skip; k < WORDS; k++) begin
                        w.instr = line[32*k +: 32];
                        w.pc    = next_line_pc + 32'(4*k);
                        w.last  = (k == WORDS-1);
                        wq.push_back(w);
                    end
                    skip         = 0;
                    next_line_pc = next_line_pc + 32'(4*WORDS);
                    req_m        = req_m + 32'(4*WORDS);
                end
                npop = pop2 ? ((cnt >= 2) ? 2 : 0) : ((pop && valid) ? 1 : 0);
                repeat (npop) void'(wq.pop_front());
            end
        end
    endtask

    task automatic idle();
        cycle(0, 0, '0, 0, 0, 0, 32'h0);
    endtask

    task automatic pop1();
        cycle(0, 0, '0, 1, 0, 0, 32'h0);
    endtask

    // Monitor: one expected record per cycle, compared shortly after the stimulus settles.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                chk("o_valid",  32'(o_valid),  32'(e.valid));
                chk("o_count",  32'(o_count),  32'(e.count));
                chk("o_full",   32'(o_full),   32'(e.full));
                chk("o_empty",  32'(o_empty),  32'(e.empty));
                chk("o_req_en", 32'(o_req_en), 32'(!e.full));
                chk("o_req_pc", o_req_pc,      e.req_pc);
                if (e.chk_data) begin
                    chk("o_instr", o_instr, e.instr);
                    chk("o_pc",    o_pc,    e.pc);
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

    initial begin
        i_rst_n = 1'b0; i_line = '0; i_line_valid = 1'b0; i_pop = 1'b0; i_pop2 = 1'b0;
        i_redirect = 1'b0; i_redirect_pc = 32'h0;
        model_reset();
        cycle(1, 0, '0, 0, 0, 0, 32'h0);
        cycle(1, 0, '0, 0, 0, 0, 32'h0);

        // two lines then eight single pops
        cycle(0, 1, mk_line(32'h100), 0, 0, 0, 32'h0);
        cycle(0, 1, mk_line(32'h104), 0, 0, 0, 32'h0);
        repeat (8) pop1();
        idle();

        // fill, drop a fifth line, free one line
        for (int i = 0; i < 5; i++) cycle(0, 1, mk_line(32'h200 + 32'(16*i)), 0, 0, 0, 32'h0);
        idle();
        repeat (4) pop1();
        idle();
        repeat (12) pop1();
        idle();

        // redirect into the middle of a line
        cycle(0, 0, '0, 0, 0, 1, 32'h48);
        idle();
        cycle(0, 1, mk_line(32'h400), 0, 0, 0, 32'h0);
        idle();

        // pop2 crossing a line boundary, then pop2 with a single word
        cycle(0, 0, '0, 0, 0, 1, 32'h0C);
        cycle(0, 1, mk_line(32'h500), 0, 0, 0, 32'h0);
        cycle(0, 1, mk_line(32'h510), 0, 0, 0, 32'h0);
        cycle(0, 0, '0, 0, 1, 0, 32'h0);
        repeat (2) pop1();
        cycle(0, 0, '0, 0, 1, 0, 32'h0);
        idle();
        pop1();
        idle();

        // redirect with a line and a pop in the same cycle
        cycle(0, 1, mk_line(32'h600), 0, 0, 0, 32'h0);
        cycle(0, 1, mk_line(32'h610), 1, 0, 1, 32'h24);
        idle();
        cycle(0, 1, mk_line(32'h620), 0, 0, 0, 32'h0);
        idle();
        repeat (2) pop1();
        idle();

`ifdef IFQ_BYPASS_EN
        cycle(0, 1, mk_line(32'h700), 1, 0, 0, 32'h0);
        idle();
        repeat (3) pop1();
        idle();
`endif

        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                cycle(1, 0, '0, 0, 0, 0, 32'h0);
            end else begin
                cycle(0, ($urandom_range(0, 1) == 1), rnd_line(),
                      ($urandom_range(0, 1) == 1), ($urandom_range(0, 6) == 0),
                      ($urandom_range(0, 29) == 0), $urandom & 32'hFFFF_FFFC);
            end
        end
        idle();
        repeat (2) @(negedge clk);
        #2;
        chk("scoreboard_drained", 32'(sb.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
